// File: rtl/johnson_seq_ctrl.sv
// Sequencing controller for a Johnson/ring phase generator: seeds a WIDTH-bit
// shift register on start, then advances it a programmed number of steps.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             mode,
  input  logic             dir,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept;
  logic run_abort;
  logic run_shift;
  logic last_shift;

  // Ring mode starts with a single hot bit in the LSB; Johnson starts empty.
  function automatic logic [WIDTH-1:0] seed_of(input logic m);
    logic [WIDTH-1:0] s;
    s    = '0;
    s[0] = m;
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] p,
                                                input logic m,
                                                input logic d);
    logic [WIDTH-1:0] r;
    case ({m, d})
      2'b00:   r = {p[WIDTH-2:0], ~p[WIDTH-1]};
      2'b01:   r = {~p[0], p[WIDTH-1:1]};
      2'b10:   r = {p[WIDTH-2:0], p[WIDTH-1]};
      default: r = {p[0], p[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    accept     = (state_q == IDLE) && start;
    run_abort  = (state_q == RUN) && abort;
    run_shift  = (state_q == RUN) && !abort && !hold;
    last_shift = run_shift && (cnt_q == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A zero-length start never enters RUN; it only reseeds and pulses done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (len != '0)) state_d = RUN;
      RUN:  if (run_abort || last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort beats hold, and hold beats the shift, so a frozen run keeps its count.
  always_comb begin
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (accept) begin
      pat_d  = seed_of(mode);
      mode_d = mode;
      dir_d  = dir;
      cnt_d  = len;
      if (len != '0) begin
        busy_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else if (run_abort) begin
      busy_d = 1'b0;
    end else if (run_shift) begin
      pat_d = shift_of(pat_q, mode_q, dir_q);
      cnt_d = cnt_q - CNT_W'(1);
      if (last_shift) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_comb begin
    q          = pat_q;
    busy       = busy_q;
    done       = done_q;
    steps_left = cnt_q;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
# johnson_seq_ctrl

Sequencing controller for a Johnson/ring phase generator. It owns a WIDTH-bit shift register, seeds it on a start request, and advances it for a programmed number of steps. Direction and mode (Johnson or ring) are latched per run, and the controller supports hold and abort. It is the control wrapper the sequential library uses wherever a counter-based phase/strobe pattern must run for a bounded, software-chosen number of steps and report completion.

## Interface
- WIDTH, 4, shift-register width (>= 2)
- CNT_W, 8, width of step-count request and remaining-step counter
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  run request; sampled only in IDLE
- len  input  CNT_W  number of shifts for the run; sampled with start
- mode  input  1  0 = Johnson (twisted ring), 1 = ring; sampled with start
- dir  input  1  0 = shift toward MSB, 1 = shift toward LSB; sampled with start
- hold  input  1  pause shifting while RUN
- abort  input  1  terminate run immediately, no done
- q  output  WIDTH  current pattern
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse after the final shift
- steps_left  output  CNT_W  remaining shifts in the current run

## Operation
- States: IDLE, RUN. All outputs are registered.
- Reset (reset=0, async): state=IDLE, q=0, busy=0, done=0, steps_left=0.
- Seed: mode 0 -> all zeros; mode 1 -> {0..0,1}.
- Shift rules, with m and d as latched at start:
  - Johnson, dir 0: q <= {q[W-2:0], ~q[W-1]}
  - Johnson, dir 1: q <= {~q[0], q[W-1:1]}
  - Ring, dir 0: q <= {q[W-2:0], q[W-1]}
  - Ring, dir 1: q <= {q[0], q[W-1:1]}
- IDLE, start=1, len!=0: q<=seed, steps_left<=len, latch mode/dir, busy<=1, go RUN.
- IDLE, start=1, len==0: q<=seed, steps_left<=0, done<=1 next cycle, stay IDLE.
- IDLE, start=0: q holds its last value.
- RUN priority per edge:
  1. abort=1: go IDLE, busy<=0, done stays 0, q and steps_left hold. abort beats hold and completion.
  2. hold=1: no shift, steps_left holds.
  3. Otherwise: shift, steps_left<=steps_left-1. If steps_left==1 (final shift): go IDLE, busy<=0, done<=1.
- done is a single-cycle pulse; it is cleared on the following edge unless re-set.
- start, len, mode, dir are ignored while busy=1. Changing mode/dir mid-run has no effect.
- start is accepted in the cycle done=1, since busy=0 there: back-to-back runs with no gap.
- abort/hold in IDLE: no effect.
- steps_left counts down without wrap. len = 2^CNT_W-1 is legal.

## Timing
- E0 = edge sampling start. After E0: busy=1, q=seed, steps_left=len.
- With hold low, shifts occur at E1..E_len. After E_len: busy=0, done=1, steps_left=0. After E_len+1: done=0.
- busy is high for exactly len + (number of RUN cycles with hold=1) cycles.
- Start-to-done latency: len+1 edges with no hold; len==0 -> 1 edge.
- Reset assertion mid-run clears everything immediately, without waiting for clk. The first start is accepted on the first rising edge after reset deasserts.

## Test plan
- Johnson left, WIDTH=4, len=8: q after E1..E8 = 0001,0011,0111,1111,1110,1100,1000,0000. done=1 only after E8; busy high 8 cycles; steps_left 8->0.
- Ring right, len=5: seed 0001, then 1000,0100,0010,0001,1000. Final q=1000, done after E5.
- Johnson left, len=4, hold=1 for 3 cycles after E2: q frozen at 0011 for those 3 cycles, busy high 7 cycles, final q=1111, done once.
- Abort during run, with hold=1 in the same cycle: busy drops next edge, done never asserts, q and steps_left frozen. A start 1 cycle later with len=2 runs normally.
- len=0: q=seed, done pulse 1 cycle after start, busy never high.
- Mid-run events:
  - reset pulse at E3: all outputs 0 asynchronously.
  - start with mode=1 while busy: ignored.
  - start in the done cycle: new run begins with zero idle gap.
